// File: rtl/jt1943_colmix_if.sv
// rtl/jt1943_colmix_if.sv - pixel, PROM-programming and video-out bundle for jt1943_colmix
//
// Purpose: groups every colour-mixer signal except clk/rst_n/cen6.
// master: the upstream video/loader side (drives pixels, enables, blanks, PROM writes).
// slave : the colour mixer (drives red/green/blue and the delayed blanks).
interface jt1943_colmix_if;
  logic       LHBL;
  logic       LVBL;
  logic [3:0] char_pxl;
  logic [5:0] obj_pxl;
  logic [5:0] scr1_pxl;
  logic [5:0] scr2_pxl;
  logic       CHON;
  logic       OBJON;
  logic       SC1ON;
  logic       SC2ON;
  logic       pause;
  logic [7:0] prog_addr;
  logic [3:0] prom_din;
  logic       prom_r_we;
  logic       prom_g_we;
  logic       prom_b_we;
  logic [3:0] red;
  logic [3:0] green;
  logic [3:0] blue;
  logic       LHBL_dly;
  logic       LVBL_dly;

  modport master (
    output LHBL, LVBL, char_pxl, obj_pxl, scr1_pxl, scr2_pxl,
    output CHON, OBJON, SC1ON, SC2ON, pause,
    output prog_addr, prom_din, prom_r_we, prom_g_we, prom_b_we,
    input  red, green, blue, LHBL_dly, LVBL_dly
  );

  modport slave (
    input  LHBL, LVBL, char_pxl, obj_pxl, scr1_pxl, scr2_pxl,
    input  CHON, OBJON, SC1ON, SC2ON, pause,
    input  prog_addr, prom_din, prom_r_we, prom_g_we, prom_b_we,
    output red, green, blue, LHBL_dly, LVBL_dly
  );
endinterface

// File: rtl/jt1943_colmix.sv
// rtl/jt1943_colmix.sv - layer priority mixer, colour PROM lookup and blanking
//
// Purpose: picks the highest-priority opaque layer pixel (char > obj > scr1 > scr2),
// looks it up in three 256x4 colour PROMs and drives blanked RGB with matching
// delayed blanking. Three-stage pipeline advanced by cen6.
// Ports:
//   clk   - system clock
//   rst_n - synchronous active-low reset
//   cen6  - pixel clock enable
//   bus   - jt1943_colmix_if.slave (pixels, enables, blanks, PROM writes, RGB out)
// Optional: define JT1943_COLMIX_DIM_EN to halve non-char pixels while paused.
module jt1943_colmix #(
  parameter int BLANK_DLY = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cen6,
  jt1943_colmix_if.slave  bus
);

  // Colour PROMs: written on any clk edge with a strobe, never reset.
  logic [3:0] prom_r [0:255];
  logic [3:0] prom_g [0:255];
  logic [3:0] prom_b [0:255];

  always_ff @(posedge clk) begin
    if (bus.prom_r_we) prom_r[bus.prog_addr] <= bus.prom_din;
    if (bus.prom_g_we) prom_g[bus.prog_addr] <= bus.prom_din;
    if (bus.prom_b_we) prom_b[bus.prog_addr] <= bus.prom_din;
  end

  // Layer selection
  logic       char_op, obj_op, scr1_op, scr2_op;
  logic [7:0] idx_nx;
  logic       black_nx;
  logic       char_win;

  always_comb begin
    // pause keeps the char layer (pause message) visible even with CHON low
    char_op  = (bus.CHON | bus.pause) & (bus.char_pxl != 4'hF);
    obj_op   = bus.OBJON & (bus.obj_pxl[3:0] != 4'hF);
    scr1_op  = bus.SC1ON & (bus.scr1_pxl[3:0] != 4'hF);
    scr2_op  = bus.SC2ON;
    idx_nx   = 8'h00;
    black_nx = 1'b0;
    char_win = 1'b0;
    if (char_op) begin
      idx_nx   = {4'b1100, bus.char_pxl};
      char_win = 1'b1;
    end else if (obj_op) begin
      idx_nx = {2'b10, bus.obj_pxl};
    end else if (scr1_op) begin
      idx_nx = {2'b01, bus.scr1_pxl};
    end else if (scr2_op) begin
      idx_nx = {2'b00, bus.scr2_pxl};
    end else begin
      black_nx = 1'b1;
    end
  end

  // Pipeline registers
  logic [7:0]           idx0;
  logic                 black0, black1;
  logic [3:0]           r1, g1, b1;
  // blank shift registers: bit 0 = S0, bit 1 = S1, top bit = output stage
  logic [BLANK_DLY-1:0] lh_sr, lv_sr;
  logic [3:0]           red_q, green_q, blue_q;

`ifdef JT1943_COLMIX_DIM_EN
  logic dim0, dim1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx0    <= 8'h00;
      black0  <= 1'b1;
      black1  <= 1'b1;
      r1      <= 4'h0;
      g1      <= 4'h0;
      b1      <= 4'h0;
      lh_sr   <= '0;
      lv_sr   <= '0;
      red_q   <= 4'h0;
      green_q <= 4'h0;
      blue_q  <= 4'h0;
`ifdef JT1943_COLMIX_DIM_EN
      dim0    <= 1'b0;
      dim1    <= 1'b0;
`endif
    end else if (cen6) begin
      // S0
      idx0   <= idx_nx;
      black0 <= black_nx;
      lh_sr  <= {lh_sr[BLANK_DLY-2:0], bus.LHBL};
      lv_sr  <= {lv_sr[BLANK_DLY-2:0], bus.LVBL};
      // S1
      black1 <= black0;
      r1     <= prom_r[idx0];
      g1     <= prom_g[idx0];
      b1     <= prom_b[idx0];
`ifdef JT1943_COLMIX_DIM_EN
      dim0   <= bus.pause & ~char_win;
      dim1   <= dim0;
`endif
      // S2
      if (black1 | ~lh_sr[1] | ~lv_sr[1]) begin
        red_q   <= 4'h0;
        green_q <= 4'h0;
        blue_q  <= 4'h0;
      end else begin
`ifdef JT1943_COLMIX_DIM_EN
        red_q   <= dim1 ? {1'b0, r1[3:1]} : r1;
        green_q <= dim1 ? {1'b0, g1[3:1]} : g1;
        blue_q  <= dim1 ? {1'b0, b1[3:1]} : b1;
`else
        red_q   <= r1;
        green_q <= g1;
        blue_q  <= b1;
`endif
      end
    end
  end

`ifndef JT1943_COLMIX_DIM_EN
  // char_win only steers dimming
  logic unused_win;
  assign unused_win = char_win;
`endif

  assign bus.red      = red_q;
  assign bus.green    = green_q;
  assign bus.blue     = blue_q;
  assign bus.LHBL_dly = lh_sr[BLANK_DLY-1];
  assign bus.LVBL_dly = lv_sr[BLANK_DLY-1];

endmodule

// File: tb/tb_jt1943_colmix.sv
// tb/tb_jt1943_colmix.sv - self-checking bench for jt1943_colmix
module tb_jt1943_colmix;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cen6 = 1'b0;
  int   checks = 0;
  int   errors = 0;

  jt1943_colmix_if bus();

  jt1943_colmix #(.BLANK_DLY(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cen6  (cen6),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // one cen6 pulse every four clocks, changed on the falling edge
  initial begin
    int cnt = 0;
    forever begin
      @(negedge clk);
      cnt = (cnt + 1) % 4;
      cen6 = (cnt == 3);
    end
  end

  // reference PROM images
  logic [3:0] m_r [0:255];
  logic [3:0] m_g [0:255];
  logic [3:0] m_b [0:255];

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
    logic       lh;
    logic       lv;
  } exp_t;

  exp_t q[$];

  // expected output for the inputs currently on the bus
  function automatic exp_t model();
    exp_t e;
    int   idx;
    bit   found, char_won, dim;
    found = 1; char_won = 0; idx = 0;
    if ((bus.CHON || bus.pause) && bus.char_pxl != 4'hF) begin
      idx = 'hC0 + int'(bus.char_pxl); char_won = 1;
    end else if (bus.OBJON && bus.obj_pxl[3:0] != 4'hF)
      idx = 'h80 + int'(bus.obj_pxl);
    else if (bus.SC1ON && bus.scr1_pxl[3:0] != 4'hF)
      idx = 'h40 + int'(bus.scr1_pxl);
    else if (bus.SC2ON)
      idx = int'(bus.scr2_pxl);
    else
      found = 0;
    e.lh = bus.LHBL;
    e.lv = bus.LVBL;
    if (!found || !bus.LHBL || !bus.LVBL) begin
      e.r = 0; e.g = 0; e.b = 0;
    end else begin
      e.r = m_r[idx]; e.g = m_g[idx]; e.b = m_b[idx];
`ifdef JT1943_COLMIX_DIM_EN
      dim = bus.pause && !char_won;
`else
      dim = 0;
`endif
      if (dim) begin
        e.r = e.r / 2; e.g = e.g / 2; e.b = e.b / 2;
      end
    end
    return e;
  endfunction

  task automatic flush_model();
    q.delete();
    q.push_back('0);
    q.push_back('0);
  endtask

  task automatic tick();
    int n = 0;
    q.push_back(model());
    if (q.size() > 3) void'(q.pop_front());
    @(posedge clk);
    while (!cen6 && n < 8) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (!cen6) begin
      errors++;
      $display("FAIL tick_timeout: cen6 never seen");
    end
    #1;
  endtask

  task automatic write_prom(input int addr, input logic [3:0] d, input logic [2:0] we);
    @(negedge clk);
    bus.prog_addr = addr[7:0];
    bus.prom_din  = d;
    {bus.prom_r_we, bus.prom_g_we, bus.prom_b_we} = we;
    @(negedge clk);
    {bus.prom_r_we, bus.prom_g_we, bus.prom_b_we} = 3'b000;
    if (we[2]) m_r[addr] = d;
    if (we[1]) m_g[addr] = d;
    if (we[0]) m_b[addr] = d;
  endtask

  task automatic set_pix(input logic [3:0] c, input logic [5:0] o, input logic [5:0] s1,
                         input logic [5:0] s2);
    bus.char_pxl = c; bus.obj_pxl = o; bus.scr1_pxl = s1; bus.scr2_pxl = s2;
  endtask

  task automatic test_reset();
    bus.LHBL = 1; bus.LVBL = 1;
    set_pix(4'hF, 6'h0F, 6'h0F, 6'h00);
    {bus.CHON, bus.OBJON, bus.SC1ON, bus.SC2ON} = 4'b1111;
    bus.pause = 0;
    bus.prog_addr = 0; bus.prom_din = 0;
    {bus.prom_r_we, bus.prom_g_we, bus.prom_b_we} = 3'b000;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.red, bus.green, bus.blue} !== 12'h000) begin
      errors++; $display("FAIL reset_rgb: got %h want 000", {bus.red, bus.green, bus.blue});
    end
    checks++;
    if ({bus.LHBL_dly, bus.LVBL_dly} !== 2'b00) begin
      errors++; $display("FAIL reset_blank: got %b want 00", {bus.LHBL_dly, bus.LVBL_dly});
    end
    @(negedge clk);
    rst_n = 1;
    flush_model();
  endtask

  task automatic load_ramp();
    for (int a = 0; a < 256; a++) write_prom(a, a[3:0], 3'b111);
  endtask

  task automatic test_priority();
    set_pix(4'h5, 6'h12, 6'h07, 6'h00);
    repeat (3) tick();
    checks++;
    if ({bus.red, bus.green, bus.blue} !== 12'h555) begin
      errors++; $display("FAIL prio_char: got %h want 555", {bus.red, bus.green, bus.blue});
    end
    set_pix(4'hF, 6'h12, 6'h07, 6'h00);
    repeat (3) tick();
    checks++;
    if ({bus.red, bus.green, bus.blue} !== 12'h222) begin
      errors++; $display("FAIL prio_obj: got %h want 222", {bus.red, bus.green, bus.blue});
    end
    set_pix(4'hF, 6'h1F, 6'h07, 6'h00);
    repeat (3) tick();
    checks++;
    if ({bus.red, bus.green, bus.blue} !== 12'h777) begin
      errors++; $display("FAIL prio_scr1: got %h want 777", {bus.red, bus.green, bus.blue});
    end
  endtask

  task automatic test_transparent();
    write_prom(0, 4'hA, 3'b111);
    set_pix(4'hF, 6'h0F, 6'h0F, 6'h00);
    bus.SC2ON = 0;
    repeat (3) tick();
    checks++;
    if ({bus.red, bus.green, bus.blue} !== 12'h000) begin
      errors++; $display("FAIL all_transparent: got %h want 000", {bus.red, bus.green, bus.blue});
    end
    bus.SC2ON = 1;
    repeat (3) tick();
    checks++;
    if ({bus.red, bus.green, bus.blue} !== 12'hAAA) begin
      errors++; $display("FAIL scr2_only: got %h want aaa", {bus.red, bus.green, bus.blue});
    end
  endtask

  task automatic test_blank_pulse();
    set_pix(4'h5, 6'h12, 6'h07, 6'h00);
    repeat (3) tick();
    bus.LHBL = 0;
    tick();
    bus.LHBL = 1;
    checks++;
    if (bus.LHBL_dly !== 1'b1) begin
      errors++; $display("FAIL blank_early: LHBL_dly got %b want 1", bus.LHBL_dly);
    end
    tick();
    tick();
    checks++;
    if ({bus.LHBL_dly, bus.red, bus.green, bus.blue} !== 13'h0000) begin
      errors++; $display("FAIL blank_hit: got %h want 0000", {bus.LHBL_dly, bus.red, bus.green, bus.blue});
    end
    tick();
    checks++;
    if ({bus.LHBL_dly, bus.LVBL_dly, bus.red} !== 6'b11_0101) begin
      errors++; $display("FAIL blank_after: got %b want 110101", {bus.LHBL_dly, bus.LVBL_dly, bus.red});
    end
  endtask

  task automatic test_pause();
    logic [11:0] want;
    bus.CHON = 0; bus.pause = 0;
    set_pix(4'h3, 6'h0F, 6'h0F, 6'h08);
    repeat (3) tick();
    checks++;
    if ({bus.red, bus.green, bus.blue} !== 12'h888) begin
      errors++; $display("FAIL chon_off: got %h want 888", {bus.red, bus.green, bus.blue});
    end
    bus.pause = 1;
    repeat (3) tick();
    checks++;
    if ({bus.red, bus.green, bus.blue} !== 12'h333) begin
      errors++; $display("FAIL pause_char: got %h want 333", {bus.red, bus.green, bus.blue});
    end
    set_pix(4'hF, 6'h0F, 6'h0F, 6'h08);
`ifdef JT1943_COLMIX_DIM_EN
    want = 12'h444;
`else
    want = 12'h888;
`endif
    repeat (3) tick();
    checks++;
    if ({bus.red, bus.green, bus.blue} !== want) begin
      errors++; $display("FAIL pause_scr2: got %h want %h", {bus.red, bus.green, bus.blue}, want);
    end
    bus.pause = 0; bus.CHON = 1;
  endtask

  task automatic test_prom_strobes();
    write_prom('h10, 4'h1, 3'b100);
    write_prom('h10, 4'h2, 3'b010);
    write_prom('h10, 4'h3, 3'b001);
    write_prom('h11, 4'h9, 3'b111);
    set_pix(4'hF, 6'h0F, 6'h0F, 6'h10);
    repeat (3) tick();
    checks++;
    if ({bus.red, bus.green, bus.blue} !== 12'h123) begin
      errors++; $display("FAIL single_strobes: got %h want 123", {bus.red, bus.green, bus.blue});
    end
    set_pix(4'hF, 6'h0F, 6'h0F, 6'h11);
    repeat (3) tick();
    checks++;
    if ({bus.red, bus.green, bus.blue} !== 12'h999) begin
      errors++; $display("FAIL multi_strobe: got %h want 999", {bus.red, bus.green, bus.blue});
    end
  endtask

  task automatic test_reset_midline();
    set_pix(4'h5, 6'h12, 6'h07, 6'h00);
    repeat (3) tick();
    @(negedge clk);
    rst_n = 0;
    @(posedge clk);
    #1;
    checks++;
    if ({bus.LHBL_dly, bus.LVBL_dly, bus.red, bus.green, bus.blue} !== 14'h0) begin
      errors++; $display("FAIL midreset: got %h want 0", {bus.LHBL_dly, bus.LVBL_dly, bus.red, bus.green, bus.blue});
    end
    @(negedge clk);
    rst_n = 1;
    flush_model();
    tick();
    checks++;
    if ({bus.LHBL_dly, bus.red} !== 5'h00) begin
      errors++; $display("FAIL release_t1: got %h want 00", {bus.LHBL_dly, bus.red});
    end
    tick();
    checks++;
    if ({bus.LHBL_dly, bus.red} !== 5'h00) begin
      errors++; $display("FAIL release_t2: got %h want 00", {bus.LHBL_dly, bus.red});
    end
    tick();
    checks++;
    if ({bus.LHBL_dly, bus.LVBL_dly, bus.red, bus.green, bus.blue} !== 14'h3555) begin
      errors++; $display("FAIL release_t3: got %h want 3555", {bus.LHBL_dly, bus.LVBL_dly, bus.red, bus.green, bus.blue});
    end
  endtask

  task automatic test_random();
    exp_t e;
    for (int a = 0; a < 256; a++) begin
      write_prom(a, 4'($urandom), 3'b100);
      write_prom(a, 4'($urandom), 3'b010);
      write_prom(a, 4'($urandom), 3'b001);
    end
    repeat (3) tick();
    for (int i = 0; i < 300; i++) begin
      // bias towards transparent nibbles so every priority level is exercised
      bus.char_pxl = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
      bus.obj_pxl  = ($urandom_range(0, 2) == 0) ? 6'($urandom) : {2'($urandom), 4'hF};
      bus.scr1_pxl = ($urandom_range(0, 1) == 0) ? 6'($urandom) : {2'($urandom), 4'hF};
      bus.scr2_pxl = 6'($urandom);
      bus.CHON  = ($urandom_range(0, 3) != 0);
      bus.OBJON = ($urandom_range(0, 3) != 0);
      bus.SC1ON = ($urandom_range(0, 3) != 0);
      bus.SC2ON = ($urandom_range(0, 3) != 0);
      bus.pause = ($urandom_range(0, 5) == 0);
      bus.LHBL  = ($urandom_range(0, 7) != 0);
      bus.LVBL  = ($urandom_range(0, 9) != 0);
      tick();
      e = q[q.size() - 3];
      checks++;
      if ({bus.red, bus.green, bus.blue, bus.LHBL_dly, bus.LVBL_dly} !== e) begin
        errors++;
        $display("FAIL random[%0d]: rgb=%h lh=%b lv=%b want rgb=%h lh=%b lv=%b", i,
                 {bus.red, bus.green, bus.blue}, bus.LHBL_dly, bus.LVBL_dly,
                 {e.r, e.g, e.b}, e.lh, e.lv);
      end
    end
  endtask

  initial begin
    test_reset();
    load_ramp();
    test_priority();
    test_transparent();
    test_blank_pulse();
    test_pause();
    test_prom_strobes();
    test_reset_midline();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jt1943_colmix.md
Name: jt1943_colmix

Overview:
- Final video stage, directly downstream of the character generator.
- Merges the 4-bit char pixel with the object and two scroll-layer pixels by fixed priority.
- Maps the winning pixel to an 8-bit palette index, reads three 256x4 colour PROMs (R, G, B) and drives blanked RGB plus matched blanking outputs to the video DAC/scaler.
- All pipeline activity advances on cen6 (one pixel per tick).

Parameters:
- BLANK_DLY, 3, number of cen6 ticks by which LHBL/LVBL are delayed. Must equal the pixel pipeline latency; values other than 3 are unsupported.

Ports:
- clk  in  1  24 MHz system clock
- rst_n  in  1  synchronous, active-low reset
- cen6  in  1  6 MHz pixel clock enable
- LHBL  in  1  horizontal blank, active low, aligned with the layer pixels
- LVBL  in  1  vertical blank, active low
- char_pxl  in  4  char layer pixel; 4'hF = transparent
- obj_pxl  in  6  object pixel; low nibble 4'hF = transparent
- scr1_pxl  in  6  front scroll pixel; low nibble 4'hF = transparent
- scr2_pxl  in  6  back scroll pixel; always opaque
- CHON, OBJON, SC1ON, SC2ON  in  1 each  layer enables
- pause  in  1  pause screen active
- prog_addr  in  8  PROM programming address
- prom_din  in  4  PROM programming data
- prom_r_we, prom_g_we, prom_b_we  in  1 each  PROM write strobes
- red, green, blue  out  4 each  colour outputs
- LHBL_dly, LVBL_dly  out  1 each  blanking delayed by BLANK_DLY

Behaviour:
- Layer opacity:
  - char is opaque iff CHON=1 and char_pxl!=4'hF.
  - obj is opaque iff OBJON=1 and obj_pxl[3:0]!=4'hF.
  - scr1 is opaque iff SC1ON=1 and scr1_pxl[3:0]!=4'hF.
  - scr2 is opaque iff SC2ON=1.
- Priority and palette index, char > obj > scr1 > scr2:
  - char: {4'b1100, char_pxl}
  - obj: {2'b10, obj_pxl}
  - scr1: {2'b01, scr1_pxl}
  - scr2: {2'b00, scr2_pxl}
- No opaque layer: index 8'h00 and force_black=1 (black output regardless of PROM contents).
- Pause: pause=1 forces char opaque whenever char_pxl!=4'hF, ignoring CHON. This keeps the pause message visible.
- Pipeline (each stage updates only when cen6=1):
  - S0: register idx, force_black, LHBL, LVBL.
  - S1: synchronous PROM read at idx; force_black and blanks carried forward.
  - S2: red/green/blue <= (force_black | ~LHBL_s1 | ~LVBL_s1) ? 0 : PROM data. LHBL_dly/LVBL_dly <= S1 copies.
  - Total latency: 3 cen6 ticks from input pixel to RGB. Blanking stays aligned with RGB.
- PROM writes:
  - Take effect on any clk edge where the strobe is high, independent of cen6.
  - Multiple strobes may be high together; each PROM then writes prom_din at prog_addr.
  - Read and write to the same address in one cycle returns the old data.
- Reset (rst_n=0 at clk edge):
  - red, green, blue = 0; LHBL_dly = LVBL_dly = 0 (blanked).
  - All pipeline registers cleared; force_black stages set to 1.
  - PROM contents are not affected.
- Reset mid-line: outputs stay black and blanked until 3 cen6 ticks after rst_n rises.
- Layer enable changes take effect on the next cen6 tick (S0); no glitch filtering.

Optional Feature:
- Macro: JT1943_COLMIX_DIM_EN.
- Defined: while pause=1, each non-blanked colour output is halved ({1'b0, c[3:1]}), except pixels won by the char layer, which keep full intensity. The pause attribute is pipelined alongside idx so dimming stays aligned with the pixel.
- Undefined: pause affects only char forcing; no dimming logic is synthesized.

Test Plan:
- Load R=G=B PROM with data = addr[3:0]; set char_pxl=4'h5, obj_pxl=6'h12, blanks high, all layers on -> after 3 cen6 ticks RGB = 5,5,5 (idx 8'hC5).
- Same setup, char_pxl=4'hF -> idx 8'h92, RGB = 2,2,2. Then obj_pxl[3:0]=4'hF, scr1_pxl=6'h07 -> RGB = 7,7,7.
- All layers transparent and SC2ON=0 -> RGB = 0 even with PROM[0]=4'hA. With SC2ON=1 and scr2_pxl=6'h00 -> RGB = A,A,A.
- Pulse LHBL low for one tick -> LHBL_dly low exactly 3 ticks later; RGB = 0 during that tick only.
- Assert rst_n=0 mid-line -> next clk: RGB = 0, LHBL_dly = LVBL_dly = 0. Release -> valid RGB from the 3rd cen6 tick.
- CHON=0, pause=1, char_pxl=4'h3 -> RGB = 3,3,3. With JT1943_COLMIX_DIM_EN defined and scr2-only pixel 8 -> RGB = 4,4,4.
